// File: rtl/ft2232h_tx_stream_pkg.sv
// Shared definitions for the FT2232H synchronous-FIFO transmit stream engine:
// pin state machine encoding, default data width and pin polarity constants.
package ft2232h_pkg;

  localparam int DEF_DATA_W = 8;

  // FT2232H control pins (WR#, TXE#, SI/WU#) are active low.
  localparam logic ACTIVE_LOW   = 1'b0;
  localparam logic INACTIVE_LOW = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } tx_state_e;

endpackage

// File: rtl/ft2232h_tx_stream_fifo.sv
// ft_sync_fifo: circular byte buffer with show-ahead head and next-head
// outputs. The caller never pushes when full nor pops when empty; the stored
// count distinguishes full from empty because the pointers wrap naturally.
module ft_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic [DATA_W-1:0]          i_push_data,
  input  logic                       i_pop,
  output logic [DATA_W-1:0]          o_head,
  output logic [DATA_W-1:0]          o_next_head,
  output logic [$clog2(DEPTH):0]     o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic [AW-1:0]     w_rd_ptr_next;

  assign w_rd_ptr_next = r_rd_ptr + AW'(1);
  assign o_head        = r_mem[r_rd_ptr];
  assign o_next_head   = r_mem[w_rd_ptr_next];
  assign o_level       = r_level;

  // Storage write port.
  // NOTE: the data array is deliberately not reset; validity is tracked by
  // r_level alone, so clearing it would only cost a reset fan-out.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  // Pointers and stored count; a simultaneous push and pop leave the count unchanged.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= w_rd_ptr_next;
      case ({i_push, i_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/ft2232h_tx_stream.sv
// ft2232h_tx_stream: valid/ready byte stream into a circular buffer, drained
// onto the FT2232H 245 synchronous FIFO pins (WR#, D). A byte is popped only
// on an edge where WR# and TXE# are both low, so TXE# rising mid-burst holds
// the presented byte and re-sends it later.
// Optional build macro FT_TX_SIWU_EN adds the siwu_n send-immediate pulse
// after SIWU_IDLE_CYC idle cycles following traffic.
module ft2232h_tx_stream
  import ft2232h_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int DEPTH         = 16,
  parameter int CNT_W         = 32,
  parameter int SIWU_IDLE_CYC = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_W-1:0]      s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic                   txe_n,
  output logic                   wr_n,
  output logic [DATA_W-1:0]      ft_data,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   busy,
  output logic [CNT_W-1:0]       tx_count
`ifdef FT_TX_SIWU_EN
  ,
  output logic                   siwu_n
`endif
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  tx_state_e         r_state;
  tx_state_e         w_state_next;
  logic              r_run;
  logic              r_wr_n;
  logic              w_wr_n_next;
  logic [DATA_W-1:0] r_ft_data;
  logic [DATA_W-1:0] w_ft_data_next;
  logic [CNT_W-1:0]  r_tx_count;
  logic [DATA_W-1:0] w_head;
  logic [DATA_W-1:0] w_next_head;
  logic [LVL_W-1:0]  w_level;
  logic              w_push;
  logic              w_accept;

  // Space is judged on the registered count only; a pop on the same edge does not free a slot.
  assign s_ready    = r_run & (w_level != LVL_W'(DEPTH));
  assign w_push     = s_valid & s_ready;
  assign w_accept   = (r_wr_n == ACTIVE_LOW) & (txe_n == ACTIVE_LOW);
  assign wr_n       = r_wr_n;
  assign ft_data    = r_ft_data;
  assign fifo_level = w_level;
  assign busy       = (r_state != IDLE);
  assign tx_count   = r_tx_count;

  ft_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data (s_data),
    .i_pop       (w_accept),
    .o_head      (w_head),
    .o_next_head (w_next_head),
    .o_level     (w_level)
  );

  // Pin FSM next-state and next pin values.
  // NOTE: every output of this block is given its hold value first, so no
  // branch can leave one unassigned and infer a latch.
  always_comb begin
    w_state_next   = r_state;
    w_wr_n_next    = r_wr_n;
    w_ft_data_next = r_ft_data;
    case (r_state)
      IDLE: begin
        if (w_level != '0) begin
          if (txe_n == ACTIVE_LOW) begin
            w_ft_data_next = w_head;
            w_wr_n_next    = ACTIVE_LOW;
            w_state_next   = SEND;
          end else begin
            w_state_next   = WAIT;
          end
        end
      end
      SEND: begin
        if (w_accept) begin
          if (w_level > LVL_W'(1)) begin
            // Another byte is already stored: keep streaming one per clock.
            w_ft_data_next = w_next_head;
          end else begin
            // Last stored byte taken; a byte pushed this edge waits for IDLE.
            w_wr_n_next    = INACTIVE_LOW;
            w_ft_data_next = '0;
            w_state_next   = IDLE;
          end
        end else begin
          w_wr_n_next  = INACTIVE_LOW;
          w_state_next = WAIT;
        end
      end
      WAIT: begin
        if (txe_n == ACTIVE_LOW) begin
          // Head is unchanged since nothing popped, so this re-presents the held byte.
          w_ft_data_next = w_head;
          w_wr_n_next    = ACTIVE_LOW;
          w_state_next   = SEND;
        end
      end
      default: begin
        w_wr_n_next    = INACTIVE_LOW;
        w_ft_data_next = '0;
        w_state_next   = IDLE;
      end
    endcase
  end

  // Pin FSM state, registered pins, transmitted-byte count and post-reset ready enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_wr_n     <= INACTIVE_LOW;
      r_ft_data  <= '0;
      r_tx_count <= '0;
      r_run      <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_wr_n    <= w_wr_n_next;
      r_ft_data <= w_ft_data_next;
      r_run     <= 1'b1;
      if (w_accept) r_tx_count <= r_tx_count + CNT_W'(1);
    end
  end

`ifdef FT_TX_SIWU_EN
  localparam int IDLE_W = $clog2(SIWU_IDLE_CYC + 1);

  logic [IDLE_W-1:0] r_idle_cnt;
  logic              r_armed;
  logic              r_siwu_n;

  assign siwu_n = r_siwu_n;

  // Idle counter and one-cycle SI/WU# pulse, armed by any accept since the last pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idle_cnt <= '0;
      r_armed    <= 1'b0;
      r_siwu_n   <= INACTIVE_LOW;
    end else begin
      r_siwu_n <= INACTIVE_LOW;
      if (w_accept) r_armed <= 1'b1;
      if ((r_state != IDLE) || (w_level != '0) || w_push) begin
        r_idle_cnt <= '0;
      end else begin
        if (r_idle_cnt != IDLE_W'(SIWU_IDLE_CYC)) r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
        if ((r_idle_cnt == IDLE_W'(SIWU_IDLE_CYC - 1)) && r_armed) begin
          r_siwu_n <= ACTIVE_LOW;
          r_armed  <= 1'b0;
        end
      end
    end
  end
`else
  // Send-immediate logic is not built; the idle-cycle parameter is left unused.
  logic w_unused_siwu_cfg;
  assign w_unused_siwu_cfg = (SIWU_IDLE_CYC > 0);
`endif

endmodule
